// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 32-bit divider among NUM_REQ requesters.
// Optional macro DIV_ARB_ZERO_CHECK_EN: answer zero-denominator requests directly with an error.
module div_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIV_LATENCY = 33
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*32-1:0]      req_num_i,
    input  logic [NUM_REQ*32-1:0]      req_den_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [31:0]                rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       div_start_o,
    output logic [31:0]                div_num_o,
    output logic [31:0]                div_den_o,
    input  logic [31:0]                div_result_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

    localparam int unsigned IdW = $clog2(NUM_REQ);
    typedef logic [IdW-1:0] id_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e               state_q;
    id_t                  last_grant_q;
    id_t                  grant_id_q;
    logic [7:0]           cnt_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [31:0]          rsp_data_q;
    logic                 div_start_q;
    logic [31:0]          div_num_q;
    logic [31:0]          div_den_q;
`ifdef DIV_ARB_ZERO_CHECK_EN
    logic                 rsp_err_q;
`endif

    id_t                  win_id;
    id_t                  cand_id;
    logic                 win_found;
    logic                 handshake;
    logic [31:0]          win_num;
    logic [31:0]          win_den;

    // Search starts one past the last owner so every waiting requester is reached in turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_id   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_id = id_t'((32'(last_grant_q) + i) % NUM_REQ);
            if (!win_found && req_valid_i[cand_id]) begin
                win_found = 1'b1;
                win_id    = cand_id;
            end
        end
    end

    assign handshake = (state_q == StIdle) && win_found && !sys_rst_i;
    assign win_num   = req_num_i[32*win_id +: 32];
    assign win_den   = req_den_i[32*win_id +: 32];

    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[win_id] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= id_t'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            div_start_q  <= 1'b0;
            div_num_q    <= '0;
            div_den_q    <= '0;
`ifdef DIV_ARB_ZERO_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            div_start_q <= 1'b0;
            rsp_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        div_num_q    <= win_num;
                        div_den_q    <= win_den;
                        grant_id_q   <= win_id;
                        last_grant_q <= win_id;
`ifdef DIV_ARB_ZERO_CHECK_EN
                        if (win_den == '0) begin
                            state_q             <= StResp;
                            rsp_valid_q[win_id] <= 1'b1;
                            rsp_data_q          <= 32'hFFFF_FFFF;
                            rsp_err_q           <= 1'b1;
                        end else begin
                            state_q     <= StIssue;
                            div_start_q <= 1'b1;
                        end
`else
                        state_q     <= StIssue;
                        div_start_q <= 1'b1;
`endif
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    cnt_q   <= 8'(DIV_LATENCY - 1);
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q                 <= StResp;
                        rsp_data_q              <= div_result_i;
                        rsp_valid_q[grant_id_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
`ifdef DIV_ARB_ZERO_CHECK_EN
                    rsp_err_q <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign div_start_o = div_start_q;
    assign div_num_o   = div_num_q;
    assign div_den_o   = div_den_q;
    assign busy_o      = (state_q != StIdle);
    assign grant_id_o  = grant_id_q;
`ifdef DIV_ARB_ZERO_CHECK_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a fixed-latency divider model.
module tb_div_arbiter;

    localparam int NR = 4;
    localparam int L  = 33;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*32-1:0] req_num = '0;
    logic [NR*32-1:0] req_den = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          div_start;
    logic [31:0]   div_num;
    logic [31:0]   div_den;
    logic [31:0]   div_result;
    logic          busy;
    logic [1:0]    grant_id;

    int checks = 0;
    int errors = 0;

    div_arbiter #(.NUM_REQ(NR), .DIV_LATENCY(L)) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .req_valid_i  (req_valid),
        .req_num_i    (req_num),
        .req_den_i    (req_den),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .div_start_o  (div_start),
        .div_num_o    (div_num),
        .div_den_o    (div_den),
        .div_result_i (div_result),
        .busy_o       (busy),
        .grant_id_o   (grant_id)
    );

    always #5 clk = ~clk;

    // Divider model: quotient presented only in the L-th cycle after the start pulse.
    logic [31:0] m_q = '0;
    int          m_cnt = 0;
    always @(posedge clk) begin
        if (div_start) begin
            m_q   <= (div_den == 0) ? 32'hFFFF_FFFF : div_num / div_den;
            m_cnt <= L;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign div_result = (m_cnt == 1) ? m_q : 32'hDEAD_BEEF;

    task automatic set_req(input int i, input logic [31:0] n, input logic [31:0] d);
        req_num[i*32 +: 32] = n;
        req_den[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps from the handshake cycle until a response appears or maxc cycles pass.
    task automatic observe(input int maxc, output int ds_k, output int ds_n, output int rsp_k,
                           output logic [NR-1:0] rvec, output logic [31:0] rdata,
                           output logic rerr);
        ds_k = -1; ds_n = 0; rsp_k = -1; rvec = '0; rdata = '0; rerr = 1'b0;
        for (int k = 1; k <= maxc && rsp_k < 0; k++) begin
            @(negedge clk);
            if (div_start) begin
                ds_n++;
                if (ds_k < 0) ds_k = k;
            end
            if (rsp_valid != '0) begin
                rsp_k = k; rvec = rsp_valid; rdata = rsp_data; rerr = rsp_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL rst_div_start got %b want 0", div_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL rst_rsp_data got %0h want 0", rsp_data); end
        checks++; if ({div_num, div_den} !== 64'd0) begin errors++; $display("FAIL rst_operands got %0h/%0h want 0/0", div_num, div_den); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int ds_k, ds_n, rsp_k; logic [NR-1:0] rvec; logic [31:0] rdata; logic rerr;
        do_reset();
        set_req(0, 32'd250000000, 32'd1000);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        observe(60, ds_k, ds_n, rsp_k, rvec, rdata, rerr);
        checks++; if (ds_k !== 1 || ds_n !== 1) begin errors++; $display("FAIL single_div_start got cycle %0d count %0d want cycle 1 count 1", ds_k, ds_n); end
        checks++; if (rsp_k !== 35) begin errors++; $display("FAIL single_latency got %0d want 35", rsp_k); end
        checks++; if (rvec !== 4'b0001 || rdata !== 32'd250000 || rerr !== 1'b0) begin
            errors++; $display("FAIL single_rsp got %b/%0d/%b want 0001/250000/0", rvec, rdata, rerr); end
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_busy_gid got %b/%0d want 1/0", busy, grant_id); end
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_data !== 32'd250000) begin
            errors++; $display("FAIL single_hold got %b/%b/%0d want 0000/0/250000", rsp_valid, busy, rsp_data); end
        checks++; if (div_num !== 32'd250000000 || div_den !== 32'd1000) begin
            errors++; $display("FAIL single_operands got %0d/%0d want 250000000/1000", div_num, div_den); end
    endtask

    task automatic test_round_robin();
        int ds_k, ds_n, rsp_k; logic [NR-1:0] rvec; logic [31:0] rdata; logic rerr;
        logic [31:0] nums [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd123456789};
        logic [31:0] dens [4] = '{32'd7, 32'd16, 32'd10, 32'd3};
        logic [31:0] quos [4] = '{32'd14, 32'h0FFF_FFFF, 32'd0, 32'd41152263};
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, nums[i], dens[i]);
        req_valid = 4'b1111;
        #1;
        for (int t = 0; t < NR; t++) begin
            checks++; if (req_ready !== 4'(1 << t)) begin errors++; $display("FAIL rr_ready_%0d got %b want %b", t, req_ready, 4'(1 << t)); end
            observe(60, ds_k, ds_n, rsp_k, rvec, rdata, rerr);
            checks++; if (rsp_k !== 35 || rvec !== 4'(1 << t)) begin
                errors++; $display("FAIL rr_rsp_%0d got cycle %0d vec %b want 35 %b", t, rsp_k, rvec, 4'(1 << t)); end
            checks++; if (rdata !== quos[t] || grant_id !== 2'(t)) begin
                errors++; $display("FAIL rr_data_%0d got %0h gid %0d want %0h gid %0d", t, rdata, grant_id, quos[t], t); end
            req_valid[t] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        int ds_k, ds_n, rsp_k; logic [NR-1:0] rvec; logic [31:0] rdata; logic rerr;
        int exp_id [3] = '{1, 2, 1};
        do_reset();
        set_req(1, 32'd1000, 32'd10);
        set_req(2, 32'd900, 32'd3);
        req_valid = 4'b0110;
        #1;
        for (int t = 0; t < 3; t++) begin
            checks++; if (req_ready !== 4'(1 << exp_id[t])) begin
                errors++; $display("FAIL fair_ready_%0d got %b want %b", t, req_ready, 4'(1 << exp_id[t])); end
            observe(60, ds_k, ds_n, rsp_k, rvec, rdata, rerr);
            checks++; if (rsp_k !== 35 || rvec !== 4'(1 << exp_id[t]) || rdata !== ((exp_id[t] == 1) ? 32'd100 : 32'd300)) begin
                errors++; $display("FAIL fair_rsp_%0d got cycle %0d vec %b data %0d", t, rsp_k, rvec, rdata); end
            if (exp_id[t] == 2) req_valid[2] = 1'b0;
            if (t == 2) req_valid = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_den();
        int ds_k, ds_n, rsp_k; logic [NR-1:0] rvec; logic [31:0] rdata; logic rerr;
        do_reset();
        set_req(3, 32'd77, 32'd0);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL zero_ready got %b want 1000", req_ready); end
        observe(60, ds_k, ds_n, rsp_k, rvec, rdata, rerr);
        req_valid = '0;
`ifdef DIV_ARB_ZERO_CHECK_EN
        checks++; if (rsp_k !== 1 || ds_n !== 0) begin errors++; $display("FAIL zero_latency got %0d starts %0d want 1 0", rsp_k, ds_n); end
        checks++; if (rvec !== 4'b1000 || rdata !== 32'hFFFF_FFFF || rerr !== 1'b1) begin
            errors++; $display("FAIL zero_rsp got %b/%0h/%b want 1000/ffffffff/1", rvec, rdata, rerr); end
`else
        checks++; if (rsp_k !== 35 || ds_n !== 1) begin errors++; $display("FAIL zero_latency got %0d starts %0d want 35 1", rsp_k, ds_n); end
        checks++; if (rvec !== 4'b1000 || rdata !== 32'hFFFF_FFFF || rerr !== 1'b0) begin
            errors++; $display("FAIL zero_rsp got %b/%0h/%b want 1000/ffffffff/0", rvec, rdata, rerr); end
`endif
        @(negedge clk);
        checks++; if (rsp_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got err %b busy %b want 0 0", rsp_err, busy); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        do_reset();
        set_req(0, 32'd5000, 32'd5);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_ready got %b want 0001", req_ready); end
        repeat (10) @(negedge clk);
        req_valid = '0;
        checks++; if (busy !== 1'b1 || div_num !== 32'd5000) begin errors++; $display("FAIL abort_pre got busy %b num %0d want 1 5000", busy, div_num); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || div_num !== 32'd0 || div_den !== 32'd0 || rsp_valid !== 4'b0 || div_start !== 1'b0) begin
            errors++; $display("FAIL abort_reset got busy %b num %0d den %0d", busy, div_num, div_den); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid != '0 || div_start || busy) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL abort_stray got %0d want 0", stray); end
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_next got %b want 0001", req_ready); end
        req_valid = '0;
        do_reset();
    endtask

    task automatic test_withdraw();
        int bad = 0;
        int got0 = -1;
        do_reset();
        set_req(0, 32'd64, 32'd8);
        set_req(2, 32'd9, 32'd3);
        req_valid = 4'b0001;
        #1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_valid[2] || req_ready[2]) bad++;
            if (rsp_valid[0] && got0 < 0) got0 = k;
            if (k == 5) req_valid[2] = 1'b1;
            if (k == 12) req_valid[2] = 1'b0;
            if (k == 35) req_valid[0] = 1'b0;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL withdraw_req2 got %0d events want 0", bad); end
        checks++; if (got0 !== 35 || rsp_data !== 32'd8) begin errors++; $display("FAIL withdraw_req0 got cycle %0d data %0d want 35 8", got0, rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_idle got busy %b want 0", busy); end
    endtask

    initial begin
        #1 rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_zero_den();
        test_reset_mid();
        test_withdraw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one 32-bit divider (range 2..8).
REQ-002 Parameter DIV_LATENCY, default 33: cycles from div_start pulse to valid div_result (range 1..255).
REQ-003 sys_clk  input  1  sole clock, all logic on rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester divide request.
REQ-006 req_num  input  NUM_REQ*32  numerators, requester i at bits [32i+31:32i].
REQ-007 req_den  input  NUM_REQ*32  denominators, same packing.
REQ-008 req_ready  output  NUM_REQ  one-hot accept strobe; handshake = req_valid[i] & req_ready[i].
REQ-009 rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-010 rsp_data  output  32  quotient for the strobed requester.
REQ-011 rsp_err  output  1  qualifies rsp_valid; high = zero denominator.
REQ-012 div_start  output  1  one-cycle start pulse to the divider.
REQ-013 div_num / div_den  output  32 each  divider operands, stable from div_start until result sampled.
REQ-014 div_result  input  32  divider quotient.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 grant_id  output  ceil(log2(NUM_REQ))  index of the current or last owner.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-018 req_ready is combinational; it is high only in IDLE, for the round-robin winner among req_valid bits.
REQ-019 Round-robin search starts at (last_grant+1) mod NUM_REQ; last_grant updates on every handshake.
REQ-020 On the handshake edge (cycle T): operands are captured into div_num/div_den, grant_id is set, and the FSM moves IDLE->ISSUE.
REQ-021 In ISSUE (T+1), div_start=1; the FSM moves to WAIT; the latency counter loads DIV_LATENCY-1.
REQ-022 WAIT decrements the counter to 0; div_result is registered into rsp_data on the edge ending cycle T+1+DIV_LATENCY; the FSM moves to RESP.
REQ-023 In RESP (T+2+DIV_LATENCY), rsp_valid[grant_id]=1 and rsp_err=0; the FSM returns to IDLE; the earliest next handshake is T+3+DIV_LATENCY.
REQ-024 req_valid dropping before handshake withdraws the request silently; req_valid changes during ISSUE/WAIT/RESP are ignored.
REQ-025 rsp_data holds its last value outside RESP; div_num/div_den hold until the next handshake.
REQ-026 Simultaneous requests: a single winner per the REQ-019 order; losers keep req_valid and win later; no requester waits more than NUM_REQ-1 transactions.

Reset
REQ-027 While sys_rst=1: FSM=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), counter=0, req_ready=0, rsp_valid=0, rsp_err=0, div_start=0, busy=0, grant_id=0, rsp_data=0, div_num=0, div_den=0.
REQ-028 Reset asserted mid-transaction aborts it: no rsp_valid is ever issued for it, and the requester must re-request.

Configuration
REQ-029 Macro DIV_ARB_ZERO_CHECK_EN defined: a handshake with den==0 skips ISSUE/WAIT and goes IDLE->RESP with rsp_data=32'hFFFFFFFF, rsp_err=1, div_start never pulsed; response latency 1 cycle after handshake.
REQ-030 Macro undefined: den==0 goes through the divider like any request; rsp_err is tied to 0.

Verification
REQ-031 Single request: req 0 num=250000000 den=1000, DIV_LATENCY=33, divider model -> div_start at T+1, rsp_valid[0] at T+35, rsp_data=250000.
REQ-032 All four valid from reset -> grants in order 0,1,2,3, each response 35 cycles after its handshake, correct quotient per requester.
REQ-033 Req 1 held valid continuously while req 2 requests once -> grants alternate 1,2,1; req 2 is never starved.
REQ-034 With DIV_ARB_ZERO_CHECK_EN: req 3 den=0 -> rsp_valid[3] one cycle after handshake, rsp_data=FFFFFFFF, rsp_err=1, no div_start pulse; without the macro: normal 35-cycle path, rsp_err=0.
REQ-035 sys_rst pulsed during WAIT -> all outputs at reset values immediately, no rsp_valid for the aborted job, next grant goes to requester 0.
REQ-036 req_valid[2] raised then dropped while busy -> no handshake and no response for requester 2.
